// File: rtl/divmod_pkg.sv
// divmod_pkg: register map, status bit positions and FSM state codes for mmio_divmod_unit.
// Optional signed mode is selected by defining DIVMOD_SIGNED_EN.
`default_nettype none

package divmod_pkg;

  localparam int ADDR_X      = 0;
  localparam int ADDR_Y      = 1;
  localparam int ADDR_REM    = 2;
  localparam int ADDR_QUO    = 3;
  localparam int ADDR_STATUS = 4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_DBZ  = 2;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t FIN  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/divmod_core.sv
// divmod_core: iterative restoring divider with start/busy/done handshake and shadow result registers.
// Define DIVMOD_SIGNED_EN for two's-complement operands (truncating division).
`default_nettype none

module divmod_core
  import divmod_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     prem_q, prem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;

  logic [WIDTH-1:0]   x_mag, y_mag, quo_fix, rem_fix;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;

`ifdef DIVMOD_SIGNED_EN
  logic qneg_q, qneg_d;
  logic xneg_q, xneg_d;

  assign x_mag   = x_i[WIDTH-1] ? -x_i : x_i;
  assign y_mag   = y_i[WIDTH-1] ? -y_i : y_i;
  // Remainder takes the dividend's sign; quotient negates when signs differ.
  assign quo_fix = qneg_q ? -quot_q : quot_q;
  assign rem_fix = xneg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
`else
  assign x_mag   = x_i;
  assign y_mag   = y_i;
  assign quo_fix = quot_q;
  assign rem_fix = prem_q[WIDTH-1:0];
`endif

  assign shifted = {prem_q[WIDTH-1:0], quot_q[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIVMOD_SIGNED_EN
    qneg_d  = qneg_q;
    xneg_d  = xneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          done_d = 1'b0;
          dbz_d  = 1'b0;
          busy_d = 1'b1;
          quot_d = x_mag;
          dvs_d  = y_mag;
          prem_d = '0;
`ifdef DIVMOD_SIGNED_EN
          qneg_d = x_i[WIDTH-1] ^ y_i[WIDTH-1];
          xneg_d = x_i[WIDTH-1];
`endif
          if (y_i == '0) begin
            // One extra FIN wait cycle keeps divide-by-zero BUSY at two cycles.
            prem_d  = {1'b0, x_i};
            cnt_d   = CNT_W'(1);
            state_d = FIN;
          end else begin
            cnt_d   = CNT_W'(WIDTH);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (diff[WIDTH+1]) begin
          prem_d = shifted;
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end else begin
          prem_d = diff[WIDTH:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIN;
      end
      FIN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (dvs_q == '0) begin
            quo_d = '1;
            rem_d = prem_q[WIDTH-1:0];
            dbz_d = 1'b1;
          end else begin
            quo_d = quo_fix;
            rem_d = rem_fix;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIVMOD_SIGNED_EN
      qneg_q  <= 1'b0;
      xneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIVMOD_SIGNED_EN
      qneg_q  <= qneg_d;
      xneg_q  <= xneg_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign dbz_o  = dbz_q;
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

`default_nettype wire

// File: rtl/mmio_divmod_unit.sv
// mmio_divmod_unit: register-bus slave wrapping divmod_core (X/Y/REM/QUO/STATUS map, registered read data).
// Define DIVMOD_SIGNED_EN to build the signed variant.
`default_nettype none

module mmio_divmod_unit
  import divmod_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 E,
  input  logic                 W,
  input  logic                 R,
  input  logic [ADDR_W-1:0]    ADDR,
  input  logic [WIDTH-1:0]     D,
  output logic [2*WIDTH-1:0]   OUT,
  output logic                 BUSY,
  output logic                 DONE
);

  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               wr, rd, start;
  logic               busy, done, dbz;
  logic [WIDTH-1:0]   quo, rem;

  assign wr    = E & W;
  assign rd    = E & R;
  assign start = wr && (ADDR == ADDR_W'(ADDR_STATUS)) && D[0] && !busy;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    out_d = out_q;
    if (wr && !busy) begin
      if (ADDR == ADDR_W'(ADDR_X)) x_d = D;
      if (ADDR == ADDR_W'(ADDR_Y)) y_d = D;
    end
    // Read mux sees pre-edge register values, so a same-edge write is not visible.
    if (rd) begin
      out_d = '0;
      case (ADDR)
        ADDR_W'(ADDR_X):      out_d[WIDTH-1:0] = x_q;
        ADDR_W'(ADDR_Y):      out_d[WIDTH-1:0] = y_q;
        ADDR_W'(ADDR_REM):    out_d[WIDTH-1:0] = rem;
        ADDR_W'(ADDR_QUO):    out_d[WIDTH-1:0] = quo;
        ADDR_W'(ADDR_STATUS): begin
          out_d[STAT_BUSY] = busy;
          out_d[STAT_DONE] = done;
          out_d[STAT_DBZ]  = dbz;
        end
        default:              out_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_q   <= '0;
      y_q   <= '0;
      out_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      out_q <= out_d;
    end
  end

  divmod_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (CLK),
    .rst     (RST),
    .start_i (start),
    .x_i     (x_q),
    .y_i     (y_q),
    .busy_o  (busy),
    .done_o  (done),
    .dbz_o   (dbz),
    .quo_o   (quo),
    .rem_o   (rem)
  );

  assign OUT  = out_q;
  assign BUSY = busy;
  assign DONE = done;

endmodule

`default_nettype wire

// File: tb/tb_mmio_divmod_unit.sv
// tb_mmio_divmod_unit: directed + random divisions checked against an arithmetic reference model.
// Define DIVMOD_SIGNED_EN to check the signed variant.
`default_nettype none

module tb_mmio_divmod_unit;

  localparam int WD = 16;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            e, w, r;
  logic [AW-1:0]   addr;
  logic [WD-1:0]   d;
  logic [2*WD-1:0] out;
  logic            busy, done;

  int total = 0;
  int bad   = 0;

  mmio_divmod_unit #(.WIDTH(WD), .ADDR_W(AW)) dut (
    .CLK(clk), .RST(rst), .E(e), .W(w), .R(r),
    .ADDR(addr), .D(d), .OUT(out), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge.
  task automatic bus_write(input int a, input logic [WD-1:0] v);
    e = 1'b1; w = 1'b1; addr = AW'(a); d = v;
    @(negedge clk);
    e = 1'b0; w = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic [2*WD-1:0] v);
    e = 1'b1; r = 1'b1; addr = AW'(a);
    @(negedge clk);
    v = out;
    e = 1'b0; r = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("busy_timeout", 64'(cyc >= 200), 64'd0);
  endtask

  function automatic void model(input logic [WD-1:0] x, input logic [WD-1:0] y,
                                output logic [WD-1:0] q, output logic [WD-1:0] rm,
                                output logic dz);
    longint sx, sy;
    dz = (y == '0);
    if (dz) begin
      q  = '1;
      rm = x;
      return;
    end
`ifdef DIVMOD_SIGNED_EN
    sx = longint'($signed(x));
    sy = longint'($signed(y));
`else
    sx = longint'(x);
    sy = longint'(y);
`endif
    q  = WD'(sx / sy);
    rm = WD'(sx % sy);
  endfunction

  task automatic run_div(input string tag, input logic [WD-1:0] x, input logic [WD-1:0] y);
    logic [WD-1:0]   eq, er;
    logic            ez;
    logic [2*WD-1:0] v;
    int              cyc;
    model(x, y, eq, er, ez);
    bus_write(0, x);
    bus_write(1, y);
    bus_write(4, 1);
    wait_idle(cyc);
    check({tag, "_busylen"}, 64'(cyc), (ez ? 64'd2 : 64'(WD + 1)));
    check({tag, "_done"}, 64'(done), 64'd1);
    bus_read(3, v); check({tag, "_quo"}, 64'(v), 64'(eq));
    bus_read(2, v); check({tag, "_rem"}, 64'(v), 64'(er));
    bus_read(4, v); check({tag, "_status"}, 64'(v), {61'd0, ez, 1'b1, 1'b0});
  endtask

  initial begin
    logic [2*WD-1:0] v;
    logic [WD-1:0]   rx, ry;
    int              cyc;

    rst = 1'b1; e = 1'b0; w = 1'b0; r = 1'b0; addr = '0; d = '0;
    repeat (2) @(negedge clk);
    check("rst_out", 64'(out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_read(4, v); check("rst_status", 64'(v), 64'd0);
    bus_read(3, v); check("rst_quo", 64'(v), 64'd0);

    run_div("d5_4", 16'd5, 16'd4);
    run_div("d445_100", 16'd445, 16'd100);
    run_div("dffff", 16'hFFFF, 16'hFFFF);
    run_div("d3_7", 16'd3, 16'd7);
    run_div("dbz", 16'd1234, 16'd0);

    // Unmapped addresses and read-during-write.
    bus_write(5, 16'h1234);
    bus_read(5, v); check("unmapped_rd", 64'(v), 64'd0);
    bus_write(0, 16'h00AA);
    e = 1'b1; w = 1'b1; r = 1'b1; addr = AW'(0); d = 16'h0055;
    @(negedge clk);
    e = 1'b0; w = 1'b0; r = 1'b0;
    check("rdw_old", 64'(out), 64'h00AA);
    bus_read(0, v); check("rdw_new", 64'(v), 64'h0055);

    // Writes and restart while busy are ignored; QUO is a shadow of the last result.
    run_div("pre", 16'd445, 16'd100);
    bus_write(0, 16'd100);
    bus_write(1, 16'd7);
    bus_write(4, 1);
    bus_write(0, 16'd9);
    bus_write(4, 1);
    check("busy_mid", 64'(busy), 64'd1);
    bus_read(3, v); check("shadow_quo", 64'(v), 64'd4);
    check("done_cleared", 64'(done), 64'd0);
    wait_idle(cyc);
    bus_read(3, v); check("busy_quo", 64'(v), 64'd14);
    bus_read(2, v); check("busy_rem", 64'(v), 64'd2);
    bus_read(0, v); check("busy_x", 64'(v), 64'd100);

    // Reset mid-run.
    bus_write(0, 16'd1000);
    bus_write(1, 16'd3);
    bus_write(4, 1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_read(3, v); check("midrst_quo", 64'(v), 64'd0);
    bus_read(2, v); check("midrst_rem", 64'(v), 64'd0);
    run_div("after_rst", 16'd1000, 16'd3);

`ifdef DIVMOD_SIGNED_EN
    run_div("s_m7_2", 16'hFFF9, 16'd2);
    run_div("s_min_m1", 16'h8000, 16'hFFFF);
    run_div("s_7_m2", 16'd7, 16'hFFFE);
`endif

    for (int i = 0; i < 20; i++) begin
      rx = WD'($urandom);
      case ($urandom_range(0, 3))
        0:       ry = WD'($urandom_range(1, 15));
        1:       ry = (i % 5 == 0) ? '0 : WD'($urandom_range(1, 255));
        default: ry = WD'($urandom);
      endcase
      run_div($sformatf("rnd%0d", i), rx, ry);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
